// File: rtl/if_fetch_pkg.sv
// Shared bus widths, rv32i constants and fetch-buffer entry type.
package if_fetch_pkg;

  localparam int InstBus       = 32;
  localparam int InstAddrBus   = 32;
  localparam int Hold_Flag_Bus = 3;

  localparam logic [InstBus-1:0]       INST_NOP     = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0]   CpuResetAddr = 32'h0000_0000;
  localparam logic [Hold_Flag_Bus-1:0] Hold_If      = 3'b010;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] addr;
  } fetch_entry_t;

  localparam int FetchEntryW = $bits(fetch_entry_t);

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/gen_dff.sv
// Enabled flop primitive with asynchronous active-low reset to a fixed value.
module gen_en_dff #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  // capture din when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    qout <= RST_VAL;
    else if (en) qout <= din;
  end

endmodule

// File: rtl/if_fetch_fifo.sv
// Small fetch buffer built from gen_en_dff; flush_i empties it on the next edge.
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_we;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop, empty, full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // a push into a full buffer is only legal when the head leaves in the same cycle
  assign do_push = push_i && (!full || do_pop);

  // pointer/count update and entry write enables
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    mem_we = '0;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_we[wr_q] = 1'b1;
        wr_d         = next_ptr(wr_q);
      end
      if (do_pop) rd_d = next_ptr(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  gen_en_dff #(.DW(PW)) u_wr  (.clk(clk), .rst(rst), .en(1'b1), .din(wr_d),  .qout(wr_q));
  gen_en_dff #(.DW(PW)) u_rd  (.clk(clk), .rst(rst), .en(1'b1), .din(rd_d),  .qout(rd_q));
  gen_en_dff #(.DW(CW)) u_cnt (.clk(clk), .rst(rst), .en(1'b1), .din(cnt_d), .qout(cnt_q));

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    gen_en_dff #(.DW(WIDTH)) u_mem (
      .clk(clk), .rst(rst), .en(mem_we[i]), .din(din_i), .qout(mem_q[i])
    );
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: single-outstanding bus master feeding a 2-entry buffer.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no request raised; waiting for buffer space and no hold
//   ST_REQ  | ibus_req_o high at pc, held until granted
//   ST_WAIT | granted, waiting for rvalid (dropped if discard_q is set)
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_i,
  input  logic [InstAddrBus-1:0]   jump_addr_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  output logic                     ibus_req_o,
  output logic [InstAddrBus-1:0]   ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [InstBus-1:0]       ibus_rdata_i,
  output logic [InstBus-1:0]       inst_o,
  output logic [InstAddrBus-1:0]   inst_addr_o,
  output logic                     inst_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] gaddr_q, gaddr_d;
  logic                   discard_q, discard_d;

  logic         hold_en, outstanding, req_allowed, gnt_ok;
  logic         fifo_flush, fifo_push, fifo_pop, fifo_nonempty;
  logic [1:0]   fifo_count, occupancy;
  fetch_entry_t fifo_din, fifo_head;

  assign hold_en       = (hold_flag_i >= Hold_If);
  assign outstanding   = (state_q == ST_WAIT);
  assign occupancy     = fifo_count + {1'b0, outstanding};
  assign req_allowed   = !hold_en && (occupancy < 2'd2);
  assign gnt_ok        = (state_q == ST_REQ) && ibus_gnt_i;
  assign fifo_nonempty = (fifo_count != 2'd0);
  assign fifo_din      = {ibus_rdata_i, gaddr_q};

  // next-state, pc and buffer control; a jump overrides everything else
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    gaddr_d    = gaddr_q;
    discard_d  = discard_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (jump_flag_i) begin
      pc_d       = word_align(jump_addr_i);
      fifo_flush = 1'b1;
      if (gnt_ok) begin
        // the old address is now on the bus; its response must be swallowed
        state_d   = ST_WAIT;
        discard_d = 1'b1;
        gaddr_d   = pc_q;
      end else if ((state_q == ST_WAIT) && !ibus_rvalid_i) begin
        state_d   = ST_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = ST_REQ;
        discard_d = 1'b0;
      end
    end else begin
      fifo_pop = inst_valid_o && !hold_en;
      case (state_q)
        ST_IDLE: if (req_allowed) state_d = ST_REQ;
        ST_REQ: begin
          // hold never withdraws a raised request
          if (ibus_gnt_i) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + 32'd4;
            gaddr_d = pc_q;
          end
        end
        ST_WAIT: begin
          if (ibus_rvalid_i) begin
            fifo_push = !discard_q;
            discard_d = 1'b0;
            // after a swallowed response the redirect target is fetched straight away
            state_d   = (discard_q || req_allowed) ? ST_REQ : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= CpuResetAddr;
      gaddr_q   <= CpuResetAddr;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      gaddr_q   <= gaddr_d;
      discard_q <= discard_d;
    end
  end

  if_fetch_fifo #(.DEPTH(2), .WIDTH(FetchEntryW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count)
  );

  // bus request and decode-side outputs
  always_comb begin
    ibus_req_o   = (state_q == ST_REQ);
    ibus_addr_o  = pc_q;
    inst_valid_o = fifo_nonempty && !jump_flag_i;
    inst_o       = inst_valid_o ? fifo_head.inst : INST_NOP;
    inst_addr_o  = inst_valid_o ? fifo_head.addr : pc_q;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a queue-based fetch-stream model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [2:0]  hold_flag_i = '0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: fetched-but-unconsumed words, next fetch pc, one bus slot
  logic [63:0] mq[$];
  logic [31:0] glog[$];
  logic [31:0] m_pc, m_gaddr, prev_addr, last_pop_addr, last_pop_inst;
  bit          m_busy, m_discard, prev_req, prev_gnt, prev_jump, stray_rv, did_jump;
  int          m_delay, gnt_pct, dly_min, dly_max, pops;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = CpuResetAddr; m_busy = 0; m_discard = 0; m_delay = 0;
    prev_req = 0; prev_gnt = 0; prev_jump = 0;
  endtask

  task automatic cycle(input int jmode, input logic [31:0] jaddr, input logic [2:0] hold);
    bit req, gnt, rv, jmp, exp_valid, held;
    logic [31:0] addr;
    logic [63:0] head;
    @(negedge clk);
    req  = ibus_req_o;
    addr = ibus_addr_o;
    if (prev_req && !prev_gnt && !prev_jump) begin
      check_val("req_stable", 32'(req), 32'd1);
      check_val("addr_stable", addr, prev_addr);
    end
    gnt = req && ($urandom_range(99) < gnt_pct);
    rv  = 0;
    if (m_busy) begin
      if (m_delay == 0) rv = 1;
      else m_delay--;
    end
    held = (hold >= Hold_If);
    case (jmode)
      0:       jmp = 0;
      1:       jmp = 1;
      default: jmp = rv && (mq.size() > 0) && !held;
    endcase
    did_jump      = jmp;
    hold_flag_i   = hold;
    jump_flag_i   = jmp;
    jump_addr_i   = jaddr;
    ibus_gnt_i    = gnt;
    ibus_rvalid_i = rv || stray_rv;
    ibus_rdata_i  = rv ? rdata_of(m_gaddr) : 32'hDEAD_BEEF;
    stray_rv      = 0;
    #1;
    check_val("ibus_addr", ibus_addr_o, m_pc);
    exp_valid = (mq.size() > 0) && !jmp;
    check_val("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      head = mq[0];
      check_val("inst", inst_o, head[63:32]);
      check_val("inst_addr", inst_addr_o, head[31:0]);
    end else begin
      check_val("inst_nop", inst_o, INST_NOP);
      if (!jmp) check_val("inst_addr_pc", inst_addr_o, m_pc);
    end
    check_val("occupancy", 32'((mq.size() + int'(m_busy)) <= 2), 32'd1);
    if (mq.size() == 2) check_val("no_req_full", 32'(req), 32'd0);
    if (jmp) begin
      mq.delete();
      if (rv) begin m_busy = 0; m_discard = 0; end
      else if (m_busy) m_discard = 1;
      if (gnt) begin
        m_busy = 1; m_discard = 1; m_gaddr = m_pc;
        m_delay = $urandom_range(dly_max, dly_min);
        glog.push_back(m_pc);
      end
      m_pc = jaddr & 32'hFFFF_FFFC;
    end else begin
      if (exp_valid && !held) begin
        head = mq.pop_front();
        pops++;
        last_pop_inst = head[63:32];
        last_pop_addr = head[31:0];
      end
      if (rv) begin
        if (!m_discard) mq.push_back({rdata_of(m_gaddr), m_gaddr});
        m_busy = 0; m_discard = 0;
      end
      if (gnt) begin
        m_busy = 1; m_gaddr = m_pc; m_pc = m_pc + 32'd4;
        m_delay = $urandom_range(dly_max, dly_min);
        glog.push_back(m_gaddr);
      end
    end
    prev_req = req; prev_gnt = gnt; prev_jump = jmp; prev_addr = addr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"}, 32'(ibus_req_o), 32'd0);
    check_val({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    check_val({tag, "_inst"}, inst_o, INST_NOP);
    check_val({tag, "_inst_addr"}, inst_addr_o, CpuResetAddr);
    check_val({tag, "_ibus_addr"}, ibus_addr_o, CpuResetAddr);
  endtask

  task automatic do_reset(input int n, input bit late_rv);
    @(negedge clk);
    rst = 1'b0;
    jump_flag_i = 0; hold_flag_i = '0; ibus_gnt_i = 0; ibus_rvalid_i = 0;
    #1;
    check_reset_outputs("rst_async");
    repeat (n) begin
      @(negedge clk);
      ibus_gnt_i = 1'($urandom); ibus_rvalid_i = 1'($urandom);
      #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    ibus_gnt_i = 0;
    ibus_rvalid_i = late_rv;
    ibus_rdata_i = 32'hDEAD_BEEF;
    model_reset();
  endtask

  task automatic run_until_pop(input int limit, input string tag);
    int p0 = pops;
    int n = 0;
    while (pops == p0 && n < limit) begin
      cycle(0, '0, 3'd0);
      n++;
    end
    check_val({tag, "_pop_seen"}, 32'(pops > p0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_addr, held_inst;
    int n, p0;
    stray_rv = 0; pops = 0; gnt_pct = 100; dly_min = 0; dly_max = 0;
    model_reset();
    do_reset(3, 1'b0);

    // straight-line stream 0,4,8 with 1-cycle response
    for (int i = 0; i < 3; i++) begin
      run_until_pop(20, "stream");
      check_val("stream_addr", last_pop_addr, 32'(i * 4));
      check_val("stream_inst", last_pop_inst, rdata_of(32'(i * 4)));
    end

    // hold for 5 cycles with a buffered head
    n = 0;
    while (mq.size() == 0 && n < 20) begin cycle(0, '0, 3'd0); n++; end
    held_inst = inst_o; held_addr = mq.size() > 0 ? mq[0][31:0] : 32'hFFFF_FFFF;
    held_inst = rdata_of(held_addr);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, Hold_If);
      check_val("hold_head_addr", inst_addr_o, held_addr);
      check_val("hold_head_inst", inst_o, held_inst);
    end
    run_until_pop(20, "hold_release");
    check_val("hold_release_addr", last_pop_addr, held_addr);

    // jump while a response is pending
    dly_min = 3; dly_max = 3; n = 0;
    while (!(m_busy && m_delay > 0) && n < 30) begin cycle(0, '0, 3'd0); n++; end
    check_val("wait_found", 32'(m_busy && m_delay > 0), 32'd1);
    cycle(1, 32'h0000_0103, 3'd0);
    glog.delete();
    dly_min = 0; dly_max = 1;
    run_until_pop(40, "jump_wait");
    check_val("jump_first_gnt", glog.size() > 0 ? glog[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    check_val("jump_first_inst_addr", last_pop_addr, 32'h0000_0100);

    // jump coinciding with rvalid and a pop
    dly_min = 0; dly_max = 2; did_jump = 0; n = 0;
    while (!did_jump && n < 3000) begin
      cycle(2, 32'h0000_0200, 3'($urandom_range(3)));
      n++;
    end
    check_val("jump_rv_pop_found", 32'(did_jump), 32'd1);
    run_until_pop(40, "jump_rv");
    check_val("jump_rv_next_addr", last_pop_addr, 32'h0000_0200);

    // wrap at the top of the address space
    dly_min = 0; dly_max = 0;
    cycle(1, 32'hFFFF_FFFC, 3'd0);
    glog.delete();
    n = 0;
    while (glog.size() < 2 && n < 40) begin cycle(0, '0, 3'd0); n++; end
    check_val("wrap_gnt0", glog.size() > 0 ? glog[0] : 32'h1234_5678, 32'hFFFF_FFFC);
    check_val("wrap_gnt1", glog.size() > 1 ? glog[1] : 32'h1234_5678, 32'h0000_0000);

    // randomised traffic with holds and jumps
    gnt_pct = 60; dly_min = 0; dly_max = 3;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(99) < 3) ? 1 : 0, $urandom,
            ($urandom_range(99) < 20) ? 3'($urandom_range(3, 2)) : 3'($urandom_range(1)));
    end
    check_val("random_progress", 32'((pops - p0) > 50), 32'd1);

    // grant withheld, then reset in the middle of a transaction
    gnt_pct = 0; n = 0;
    while (!ibus_req_o && n < 40) begin cycle(0, '0, 3'd0); n++; end
    check_val("withhold_req_seen", 32'(ibus_req_o), 32'd1);
    repeat (4) cycle(0, '0, 3'd0);
    gnt_pct = 100; dly_min = 10; dly_max = 10;
    cycle(0, '0, 3'd0);
    check_val("mid_wait_granted", 32'(m_busy), 32'd1);
    repeat (2) cycle(0, '0, 3'd0);
    do_reset(2, 1'b1);
    stray_rv = 1;
    dly_min = 0; dly_max = 0;
    run_until_pop(20, "restart");
    check_val("restart_addr", last_pop_addr, 32'h0000_0000);
    check_val("restart_inst", last_pop_inst, rdata_of(32'h0000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
